// File: rtl/noc_out_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// noc_out_arbiter : per-output wormhole arbiter (round-robin, packet lock, credits)
// Revision 1.0
// ----------------------------------------------------------------------------
module noc_out_arbiter #(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [4:0]    req_i,
  input  logic [4:0]    tail_i,
  input  logic          credit_i,
  output logic [3:0]    sel_o,
  output logic [4:0]    grant_o,
  output logic          valid_o,
  output logic          busy_o,
  output logic [CW-1:0] credit_cnt_o,
  output logic          credit_err_o
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(CREDITS);

  state_t        state, state_nxt;
  logic [2:0]    owner, owner_nxt;
  logic [2:0]    ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err, err_nxt;
  logic [2:0]    pick;
  logic [3:0]    idx;
  logic          found;
  logic [4:0]    owner_oh;
  logic          xfer;

  // Round-robin search starting at ptr, wrapping modulo 5.
  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    idx   = 4'd0;
    for (int i = 0; i < 5; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && req_i[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
  end

  assign owner_oh = 5'b00001 << owner;
  assign xfer     = (state == LOCKED) && (|(req_i & owner_oh)) && (cnt != '0);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    sel_o     = 4'b0111;
    grant_o   = 5'b00000;
    valid_o   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = pick;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        sel_o = {1'b0, owner};
        if (xfer) begin
          grant_o = owner_oh;
          valid_o = 1'b1;
          if (|(tail_i & owner_oh)) begin
            state_nxt = IDLE;
            ptr_nxt   = (owner == 3'd4) ? 3'd0 : owner + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A credit and a transfer in the same cycle cancel out.
  always_comb begin
    cnt_nxt = cnt;
    err_nxt = err;
    if (credit_i && !xfer) begin
      if (cnt == CNT_MAX) err_nxt = 1'b1;
      else                cnt_nxt = cnt + 1'b1;
    end else if (xfer && !credit_i) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= 3'd0;
      ptr   <= 3'd0;
      cnt   <= CNT_MAX;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  assign busy_o       = (state == LOCKED);
  assign credit_cnt_o = cnt;
  assign credit_err_o = err;

endmodule
`default_nettype wire

// File: tb/tb_noc_out_arbiter.sv
`default_nettype none
// tb_noc_out_arbiter : scoreboard bench with a behavioural reference model
module tb_noc_out_arbiter;

  localparam int CREDITS = 4;
  localparam int CW      = $clog2(CREDITS + 1);

  logic          clk = 1'b0;
  logic          rst_i;
  logic [4:0]    req_i, tail_i;
  logic          credit_i;
  logic [3:0]    sel_o;
  logic [4:0]    grant_o;
  logic          valid_o, busy_o, credit_err_o;
  logic [CW-1:0] credit_cnt_o;

  noc_out_arbiter #(.CREDITS(CREDITS)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .tail_i(tail_i),
    .credit_i(credit_i), .sel_o(sel_o), .grant_o(grant_o), .valid_o(valid_o),
    .busy_o(busy_o), .credit_cnt_o(credit_cnt_o), .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    sel;
    logic [4:0]    grant;
    logic          valid;
    logic          busy;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  logic          m_locked = 1'b0;
  int            m_owner  = 0;
  int            m_ptr    = 0;
  int            m_cnt    = CREDITS;
  logic          m_err    = 1'b0;
  logic          m_xfer;

  // last observed DUT outputs
  logic [3:0]    ob_sel;
  logic [4:0]    ob_grant;
  logic          ob_busy, ob_err;
  logic [CW-1:0] ob_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] q, input logic [4:0] t,
                      input logic c, input logic do_chk);
    exp_t e;
    exp_t got;
    rst_i = r; req_i = q; tail_i = t; credit_i = c;
    m_xfer  = m_locked && q[m_owner] && (m_cnt != 0);
    e.sel   = m_locked ? 4'(m_owner) : 4'b0111;
    e.grant = m_xfer ? 5'(1 << m_owner) : 5'b0;
    e.valid = m_xfer;
    e.busy  = m_locked;
    e.cnt   = CW'(m_cnt);
    e.err   = m_err;
    if (do_chk) sb.push_back(e);
    @(negedge clk);
    ob_sel = sel_o; ob_grant = grant_o; ob_busy = busy_o;
    ob_err = credit_err_o; ob_cnt = credit_cnt_o;
    if (do_chk) begin
      got = sb.pop_front();
      check_val("sel",     32'(sel_o),        32'(got.sel));
      check_val("grant",   32'(grant_o),      32'(got.grant));
      check_val("valid",   32'(valid_o),      32'(got.valid));
      check_val("busy",    32'(busy_o),       32'(got.busy));
      check_val("cnt",     32'(credit_cnt_o), 32'(got.cnt));
      check_val("err",     32'(credit_err_o), 32'(got.err));
    end
    @(posedge clk);
    if (r) begin
      m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = CREDITS; m_err = 1'b0;
    end else begin
      if (!m_locked && q != 5'b0) begin
        for (int i = 0; i < 5; i++) begin
          if (!m_locked && q[(m_ptr + i) % 5]) begin
            m_owner  = (m_ptr + i) % 5;
            m_locked = 1'b1;
          end
        end
      end else if (m_locked && m_xfer && t[m_owner]) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % 5;
      end
      if (c && !m_xfer) begin
        if (m_cnt == CREDITS) m_err = 1'b1;
        else                  m_cnt = m_cnt + 1;
      end else if (m_xfer && !c) begin
        m_cnt = m_cnt - 1;
      end
    end
    #1;
  endtask

  logic [4:0] rr_log[$];
  logic [4:0] rr_exp[6];
  logic       lx;

  initial begin
    rst_i = 1'b1; req_i = '0; tail_i = '0; credit_i = 1'b0;
    rr_exp[0] = 5'b00001; rr_exp[1] = 5'b00010; rr_exp[2] = 5'b00100;
    rr_exp[3] = 5'b01000; rr_exp[4] = 5'b10000; rr_exp[5] = 5'b00001;
    @(posedge clk); #1;

    // reset and a 3-flit packet from E
    step(1, 5'b0, 5'b0, 0, 0);
    step(1, 5'b0, 5'b0, 0, 1);
    step(0, 5'b0, 5'b0, 0, 1);
    check_val("rst_sel", 32'(ob_sel), 32'h7);
    check_val("rst_cnt", 32'(ob_cnt), 32'd4);
    check_val("rst_busy", 32'(ob_busy), 32'd0);
    step(0, 5'b00100, 5'b0, 0, 1);
    step(0, 5'b00100, 5'b0, 0, 1);
    check_val("e_grant1", 32'(ob_grant), 32'h04);
    step(0, 5'b00100, 5'b0, 0, 1);
    step(0, 5'b00100, 5'b00100, 0, 1);
    check_val("e_grant3", 32'(ob_grant), 32'h04);
    step(0, 5'b0, 5'b0, 0, 1);
    check_val("e_cnt", 32'(ob_cnt), 32'd1);
    check_val("e_idle", 32'(ob_busy), 32'd0);

    // round-robin fairness, single-flit packets, credit returned after each flit
    step(1, 5'b0, 5'b0, 0, 1);
    lx = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(0, 5'b11111, 5'b11111, lx, 1);
      if (ob_grant != 5'b0) rr_log.push_back(ob_grant);
      lx = m_xfer;
    end
    check_val("rr_count", 32'(rr_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < rr_log.size()) check_val($sformatf("rr_order%0d", i), 32'(rr_log[i]), 32'(rr_exp[i]));
    end

    // credit stall: 6-flit packet from S with 4 credits
    step(1, 5'b0, 5'b0, 0, 1);
    step(0, 5'b00010, 5'b0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 5'b00010, 5'b0, 0, 1);
    step(0, 5'b00010, 5'b0, 0, 1);
    check_val("stall_grant", 32'(ob_grant), 32'h0);
    check_val("stall_busy", 32'(ob_busy), 32'd1);
    step(0, 5'b00010, 5'b0, 0, 1);
    step(0, 5'b00010, 5'b0, 1, 1);
    check_val("credit_same_cycle", 32'(ob_grant), 32'h0);
    step(0, 5'b00010, 5'b0, 0, 1);
    check_val("credit_resume", 32'(ob_grant), 32'h02);
    step(0, 5'b00010, 5'b0, 0, 1);
    check_val("stall_again", 32'(ob_grant), 32'h0);
    step(0, 5'b00010, 5'b0, 1, 1);
    step(0, 5'b00010, 5'b00010, 0, 1);
    step(0, 5'b0, 5'b0, 0, 1);

    // lock hold: W drops request while N asks
    step(1, 5'b0, 5'b0, 0, 1);
    step(0, 5'b01000, 5'b0, 0, 1);
    step(0, 5'b01000, 5'b0, 0, 1);
    step(0, 5'b00001, 5'b0, 0, 1);
    step(0, 5'b00001, 5'b0, 0, 1);
    check_val("hold_sel", 32'(ob_sel), 32'h3);
    check_val("hold_grant", 32'(ob_grant), 32'h0);
    step(0, 5'b01001, 5'b0, 0, 1);
    check_val("hold_resume", 32'(ob_grant), 32'h08);
    step(0, 5'b01001, 5'b01000, 0, 1);
    step(0, 5'b00001, 5'b00001, 0, 1);
    step(0, 5'b00001, 5'b00001, 0, 1);
    check_val("after_w_n", 32'(ob_grant), 32'h01);

    // credit + transfer at cnt=2, then overflow error
    step(1, 5'b0, 5'b0, 0, 1);
    step(0, 5'b00001, 5'b0, 0, 1);
    step(0, 5'b00001, 5'b0, 0, 1);
    step(0, 5'b00001, 5'b0, 0, 1);
    step(0, 5'b00001, 5'b0, 1, 1);
    step(0, 5'b00001, 5'b00001, 0, 1);
    check_val("cnt_hold2", 32'(ob_cnt), 32'd2);
    for (int i = 0; i < 3; i++) step(0, 5'b0, 5'b0, 1, 1);
    step(0, 5'b0, 5'b0, 1, 1);
    check_val("cnt_full", 32'(ob_cnt), 32'd4);
    step(0, 5'b0, 5'b0, 0, 1);
    check_val("err_set", 32'(ob_err), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 5'b0, 5'b0, 0, 1);
    check_val("err_sticky", 32'(ob_err), 32'd1);

    // reset on flit 2 of a local packet
    step(1, 5'b0, 5'b0, 0, 1);
    step(0, 5'b10000, 5'b0, 0, 1);
    step(0, 5'b10000, 5'b0, 0, 1);
    step(1, 5'b10000, 5'b0, 0, 1);
    check_val("midrst_flit2", 32'(ob_grant), 32'h10);
    step(0, 5'b10001, 5'b0, 0, 1);
    check_val("midrst_sel", 32'(ob_sel), 32'h7);
    check_val("midrst_cnt", 32'(ob_cnt), 32'd4);
    check_val("midrst_err", 32'(ob_err), 32'd0);
    step(0, 5'b10001, 5'b00001, 0, 1);
    check_val("midrst_n_first", 32'(ob_grant), 32'h01);
    step(0, 5'b0, 5'b0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
